// File: rtl/bp_gshare.sv
// -----------------------------------------------------------------------------
// bp_gshare
//   Gshare branch predictor for the Ibex fetch stage. A pattern history table
//   (PHT) of saturating counters is indexed by fetch PC[IdxW:1] XOR the global
//   history register (GHR). Predicted directions of conditional branches are
//   shifted into the GHR speculatively. When EX reports a mispredict, the GHR
//   is rebuilt from the history captured with that branch. The PHT has no
//   per-entry reset. After reset it is filled by a sequential sweep that
//   writes one entry per cycle.
//
// Ports
//   clk_i                  clock, all state updates on the rising edge
//   rst_i                  synchronous active-high reset
//   fetch_rdata_i          instruction word at the fetch PC (RVC in [15:0])
//   fetch_pc_i             fetch PC
//   fetch_valid_i          fetch_rdata_i / fetch_pc_i valid
//   predict_branch_taken_o combinational taken prediction
//   predict_branch_pc_o    combinational target, fetch_pc_i + immediate
//   predict_ghr_o          GHR used for this prediction (carried down the pipe)
//   ex_br_valid_i          EX resolved a conditional branch this cycle
//   ex_br_instr_addr_i     PC of the resolved branch
//   ex_br_taken_i          actual direction
//   ex_br_mispredict_i     direction was mispredicted (qualified by valid)
//   ex_ghr_i               predict_ghr_o value that travelled with the branch
//   init_done_o            PHT sweep finished, predictor live
// -----------------------------------------------------------------------------
module bp_gshare #(
  parameter int unsigned CTableSize = 256,
  parameter int unsigned CounterLen = 2,
  parameter int unsigned GhrLen     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       fetch_rdata_i,
  input  logic [31:0]       fetch_pc_i,
  input  logic              fetch_valid_i,
  output logic              predict_branch_taken_o,
  output logic [31:0]       predict_branch_pc_o,
  output logic [GhrLen-1:0] predict_ghr_o,
  input  logic              ex_br_valid_i,
  input  logic [31:0]       ex_br_instr_addr_i,
  input  logic              ex_br_taken_i,
  input  logic              ex_br_mispredict_i,
  input  logic [GhrLen-1:0] ex_ghr_i,
  output logic              init_done_o
);

  localparam int unsigned IdxW = $clog2(CTableSize);

  localparam logic [CounterLen-1:0] CtrInit = {1'b1, {(CounterLen-1){1'b0}}};
  localparam logic [CounterLen-1:0] CtrMax  = {CounterLen{1'b1}};
  localparam logic [IdxW-1:0]       IdxLast = IdxW'(CTableSize - 1);

  localparam logic [6:0] OpcodeBranch = 7'h63;
  localparam logic [6:0] OpcodeJal    = 7'h6f;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Saturating counter increment.
  function automatic logic [CounterLen-1:0] ctr_inc(input logic [CounterLen-1:0] c);
    if (c == CtrMax) begin
      return c;
    end else begin
      return c + CounterLen'(1);
    end
  endfunction

  // Saturating counter decrement.
  function automatic logic [CounterLen-1:0] ctr_dec(input logic [CounterLen-1:0] c);
    if (c == {CounterLen{1'b0}}) begin
      return c;
    end else begin
      return c - CounterLen'(1);
    end
  endfunction

  // Shift one direction bit into a history value. The extra bit of headroom
  // keeps this legal when GhrLen is 1.
  function automatic logic [GhrLen-1:0] ghr_push(input logic [GhrLen-1:0] h,
                                                 input logic              b);
    logic [GhrLen:0] t;
    t = {h, b};
    return t[GhrLen-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                state_r;
  logic [IdxW-1:0]       init_idx_r;
  logic [GhrLen-1:0]     ghr_r;
  logic                  init_done_r;
  logic [CounterLen-1:0] pht_r [CTableSize];

  // ---------------------------------------------------------------------------
  // Instruction decode (same decode as the bimodal predictor)
  // ---------------------------------------------------------------------------
  logic        is_b_s, is_j_s, is_cj_s, is_cb_s, is_c_s;
  logic        cond_s, jump_s;
  logic [31:0] imm_b_s, imm_j_s, imm_cj_s, imm_cb_s, imm_s;

  assign imm_j_s  = {{12{fetch_rdata_i[31]}}, fetch_rdata_i[19:12], fetch_rdata_i[20],
                     fetch_rdata_i[30:21], 1'b0};
  assign imm_b_s  = {{19{fetch_rdata_i[31]}}, fetch_rdata_i[31], fetch_rdata_i[7],
                     fetch_rdata_i[30:25], fetch_rdata_i[11:8], 1'b0};
  assign imm_cj_s = {{20{fetch_rdata_i[12]}}, fetch_rdata_i[12], fetch_rdata_i[8],
                     fetch_rdata_i[10:9], fetch_rdata_i[6], fetch_rdata_i[7],
                     fetch_rdata_i[2], fetch_rdata_i[11], fetch_rdata_i[5:3], 1'b0};
  assign imm_cb_s = {{23{fetch_rdata_i[12]}}, fetch_rdata_i[12], fetch_rdata_i[6:5],
                     fetch_rdata_i[2], fetch_rdata_i[11:10], fetch_rdata_i[4:3], 1'b0};

  assign is_c_s  = (fetch_rdata_i[1:0] != 2'b11);
  assign is_b_s  = (fetch_rdata_i[6:0] == OpcodeBranch);
  assign is_j_s  = (fetch_rdata_i[6:0] == OpcodeJal);
  // C.J (101) and C.JAL (001, RV32 only) in quadrant 1.
  assign is_cj_s = is_c_s & (fetch_rdata_i[1:0] == 2'b01) &
                   ((fetch_rdata_i[15:13] == 3'b101) | (fetch_rdata_i[15:13] == 3'b001));
  // C.BEQZ (110) and C.BNEZ (111) in quadrant 1.
  assign is_cb_s = is_c_s & (fetch_rdata_i[1:0] == 2'b01) &
                   ((fetch_rdata_i[15:13] == 3'b110) | (fetch_rdata_i[15:13] == 3'b111));

  assign cond_s = is_b_s | is_cb_s;
  assign jump_s = is_j_s | is_cj_s;

  // Select the immediate that belongs to the decoded instruction type.
  always_comb begin
    imm_s = 32'd0;
    if (is_j_s) begin
      imm_s = imm_j_s;
    end else if (is_cj_s) begin
      imm_s = imm_cj_s;
    end else if (is_b_s) begin
      imm_s = imm_b_s;
    end else if (is_cb_s) begin
      imm_s = imm_cb_s;
    end else begin
      imm_s = 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Prediction (combinational read of the PHT, no write bypass)
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] pred_idx_s;
  logic            pht_msb_s;
  logic            cond_taken_s;

  assign pred_idx_s   = fetch_pc_i[IdxW:1] ^ IdxW'(ghr_r);
  assign pht_msb_s    = pht_r[pred_idx_s][CounterLen-1];
  // Until the sweep finishes, the table holds garbage, so conditional branches
  // fall back to not-taken.
  assign cond_taken_s = pht_msb_s & init_done_r;

  assign predict_branch_taken_o = fetch_valid_i & (jump_s | (cond_s & cond_taken_s));
  assign predict_branch_pc_o    = fetch_pc_i + imm_s;
  assign predict_ghr_o          = ghr_r;
  assign init_done_o            = init_done_r;

  // ---------------------------------------------------------------------------
  // PHT write port: sweep during INIT, EX training during RUN
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0]       upd_idx_s;
  logic [CounterLen-1:0] upd_ctr_s;
  logic                  pht_we_s;
  logic [IdxW-1:0]       pht_waddr_s;
  logic [CounterLen-1:0] pht_wdata_s;

  assign upd_idx_s = ex_br_instr_addr_i[IdxW:1] ^ IdxW'(ex_ghr_i);
  assign upd_ctr_s = pht_r[upd_idx_s];

  // Choose the single PHT write of this cycle.
  always_comb begin
    pht_we_s    = 1'b0;
    pht_waddr_s = {IdxW{1'b0}};
    pht_wdata_s = {CounterLen{1'b0}};
    if (rst_i) begin
      pht_we_s = 1'b0;
    end else if (state_r == ST_INIT) begin
      pht_we_s    = 1'b1;
      pht_waddr_s = init_idx_r;
      pht_wdata_s = CtrInit;
    end else if (ex_br_valid_i) begin
      pht_we_s    = 1'b1;
      pht_waddr_s = upd_idx_s;
      pht_wdata_s = ex_br_taken_i ? ctr_inc(upd_ctr_s) : ctr_dec(upd_ctr_s);
    end else begin
      pht_we_s = 1'b0;
    end
  end

  // PHT storage. It is deliberately not reset because the sweep initialises it.
  always_ff @(posedge clk_i) begin
    if (pht_we_s) begin
      pht_r[pht_waddr_s] <= pht_wdata_s;
    end
  end

  // ---------------------------------------------------------------------------
  // GHR next state in RUN: mispredict recovery beats speculative shift
  // ---------------------------------------------------------------------------
  logic [GhrLen-1:0] ghr_next_s;

  // Next GHR value. A fetch in the same cycle as a mispredict is wrong-path.
  always_comb begin
    ghr_next_s = ghr_r;
    if (ex_br_valid_i & ex_br_mispredict_i) begin
      ghr_next_s = ghr_push(ex_ghr_i, ex_br_taken_i);
    end else if (fetch_valid_i & cond_s) begin
      ghr_next_s = ghr_push(ghr_r, cond_taken_s);
    end else begin
      ghr_next_s = ghr_r;
    end
  end

  // Control FSM: INIT sweep, then RUN. It also owns the GHR and the ready flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_INIT;
      init_idx_r  <= {IdxW{1'b0}};
      ghr_r       <= {GhrLen{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          init_idx_r <= init_idx_r + IdxW'(1);
          ghr_r      <= {GhrLen{1'b0}};
          if (init_idx_r == IdxLast) begin
            state_r     <= ST_RUN;
            init_done_r <= 1'b1;
          end
        end
        ST_RUN: begin
          ghr_r <= ghr_next_s;
        end
        default: begin
          state_r     <= ST_INIT;
          init_idx_r  <= {IdxW{1'b0}};
          ghr_r       <= {GhrLen{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Address bits that never take part in indexing.
  logic unused_addr_s;
  assign unused_addr_s = ^{ex_br_instr_addr_i[31:IdxW+1], ex_br_instr_addr_i[0]};

endmodule

// File: tb/tb_bp_gshare.sv
module tb_bp_gshare;

  localparam int K_TAKEN = 0;
  localparam int K_PC    = 1;
  localparam int K_GHR   = 2;
  localparam int K_DONE  = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] fetch_rdata_i;
  logic [31:0] fetch_pc_i;
  logic        fetch_valid_i;
  logic        predict_branch_taken_o;
  logic [31:0] predict_branch_pc_o;
  logic [7:0]  predict_ghr_o;
  logic        ex_br_valid_i;
  logic [31:0] ex_br_instr_addr_i;
  logic        ex_br_taken_i;
  logic        ex_br_mispredict_i;
  logic [7:0]  ex_ghr_i;
  logic        init_done_o;

  always #5 clk_i = ~clk_i;

  bp_gshare dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .fetch_rdata_i          (fetch_rdata_i),
    .fetch_pc_i             (fetch_pc_i),
    .fetch_valid_i          (fetch_valid_i),
    .predict_branch_taken_o (predict_branch_taken_o),
    .predict_branch_pc_o    (predict_branch_pc_o),
    .predict_ghr_o          (predict_ghr_o),
    .ex_br_valid_i          (ex_br_valid_i),
    .ex_br_instr_addr_i     (ex_br_instr_addr_i),
    .ex_br_taken_i          (ex_br_taken_i),
    .ex_br_mispredict_i     (ex_br_mispredict_i),
    .ex_ghr_i               (ex_ghr_i),
    .init_done_o            (init_done_o)
  );

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   checks_total  = 0;
  int   checks_passed = 0;

  // Scoreboard monitor: on each falling edge, drain and compare everything queued.
  chk_t        mon_c;
  logic [31:0] mon_act;
  always @(negedge clk_i) begin
    while (sb_q.size() > 0) begin
      mon_c = sb_q.pop_front();
      case (mon_c.kind)
        K_TAKEN: mon_act = {31'd0, predict_branch_taken_o};
        K_PC:    mon_act = predict_branch_pc_o;
        K_GHR:   mon_act = {24'd0, predict_ghr_o};
        K_DONE:  mon_act = {31'd0, init_done_o};
        default: mon_act = 32'hDEAD_BEEF;
      endcase
      checks_total++;
      if (mon_act === mon_c.exp) begin
        checks_passed++;
      end else begin
        $display("FAIL %s: got 0x%08h expected 0x%08h", mon_c.name, mon_act, mon_c.exp);
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic push(input string name, input int kind, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    fetch_valid_i      = 1'b0;
    fetch_rdata_i      = 32'h0000_0013;
    fetch_pc_i         = 32'd0;
    ex_br_valid_i      = 1'b0;
    ex_br_instr_addr_i = 32'd0;
    ex_br_taken_i      = 1'b0;
    ex_br_mispredict_i = 1'b0;
    ex_ghr_i           = 8'd0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    fetch_valid_i = 1'b1;
    fetch_pc_i    = pc;
    fetch_rdata_i = instr;
  endtask

  task automatic ex(input logic [31:0] addr, input logic [7:0] ghr, input logic tk,
                    input logic mp);
    ex_br_valid_i      = 1'b1;
    ex_br_instr_addr_i = addr;
    ex_ghr_i           = ghr;
    ex_br_taken_i      = tk;
    ex_br_mispredict_i = mp;
  endtask

  task automatic exp_pred(input string name, input logic tk, input logic [31:0] tgt);
    push({name, "_taken"}, K_TAKEN, {31'd0, tk});
    push({name, "_pc"}, K_PC, tgt);
  endtask

  // Fetch with a concurrent recovery to history 0 (PHT side effect on index 0xFF).
  task automatic probe(input string name, input logic [31:0] pc, input logic [31:0] instr,
                       input logic tk, input logic [31:0] tgt);
    clr();
    fetch(pc, instr);
    ex(32'h0000_01FE, 8'h00, 1'b0, 1'b1);
    exp_pred(name, tk, tgt);
    step();
  endtask

  // Instruction encoders.
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int off);
    logic [12:0] i;
    i = 13'(off);
    return {i[12], i[10:5], 5'd0, 5'd0, f3, i[4:1], i[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] i;
    i = 21'(off);
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_cj(input logic [2:0] f3, input int off);
    logic [11:0] i;
    i = 12'(off);
    return {16'h0000, f3, i[11], i[4], i[9:8], i[10], i[6], i[7], i[3:1], i[5], 2'b01};
  endfunction

  function automatic logic [31:0] enc_cbeqz(input int off);
    logic [8:0] i;
    i = 9'(off);
    return {16'h0000, 3'b110, i[8], i[4:3], 3'b000, i[7:6], i[2:1], i[5], 2'b01};
  endfunction

  initial begin
    clr();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    push("reset_ghr", K_GHR, 32'h0);

    // T1: sweep with stimulus during INIT
    for (int i = 0; i < 256; i++) begin
      clr();
      push("t1_init_done_low", K_DONE, 32'h0);
      if (i == 3) begin
        fetch(32'h100, enc_b(3'b000, 16));
        exp_pred("t1_beq_init", 1'b0, 32'h110);
      end else if (i == 4) begin
        fetch(32'h200, enc_jal(64));
        exp_pred("t1_jal_init", 1'b1, 32'h240);
        push("t1_ghr_no_shift_init", K_GHR, 32'h0);
      end else if (i == 5) begin
        fetch(32'h300, enc_cbeqz(16));
        exp_pred("t1_cbeqz_init", 1'b0, 32'h310);
      end else if (i == 10) begin
        ex(32'h3FE, 8'h00, 1'b1, 1'b1);
      end else if (i == 11) begin
        push("t1_ghr_held_init", K_GHR, 32'h0);
      end else if (i == 12 || i == 13) begin
        ex(32'h002, 8'h00, 1'b0, 1'b0);
      end
      step();
    end
    clr();
    push("t1_init_done_high", K_DONE, 32'h1);
    push("t1_ghr_run", K_GHR, 32'h0);
    // EX updates in INIT were dropped: index 1 is still weakly taken.
    fetch(32'h002, enc_b(3'b000, 16));
    exp_pred("t1_ex_dropped", 1'b1, 32'h12);
    step();
    clr();
    fetch_rdata_i = enc_b(3'b000, 16);
    fetch_pc_i    = 32'h002;
    push("t1_novalid_taken", K_TAKEN, 32'h0);
    push("t1_ghr_shift", K_GHR, 32'h1);
    step();

    // T2: saturation at index 0x80
    clr();
    ex(32'h1FE, 8'h00, 1'b0, 1'b1);
    step();
    clr();
    push("t2_ghr_clear", K_GHR, 32'h0);
    for (int i = 0; i < 5; i++) begin clr(); ex(32'h100, 8'h00, 1'b1, 1'b0); step(); end
    probe("t2_sat_hi", 32'h100, enc_b(3'b000, 16), 1'b1, 32'h110);
    for (int i = 0; i < 5; i++) begin clr(); ex(32'h100, 8'h00, 1'b0, 1'b0); step(); end
    probe("t2_sat_lo", 32'h100, enc_b(3'b000, 16), 1'b0, 32'h110);
    for (int i = 0; i < 5; i++) begin clr(); ex(32'h100, 8'h00, 1'b1, 1'b0); step(); end
    probe("t2_sat_hi2", 32'h100, enc_b(3'b000, 16), 1'b1, 32'h110);
    clr(); ex(32'h100, 8'h00, 1'b0, 1'b0); step();
    probe("t2_ctr2", 32'h100, enc_b(3'b000, 16), 1'b1, 32'h110);
    clr(); ex(32'h100, 8'h00, 1'b0, 1'b0); step();
    probe("t2_ctr1", 32'h100, enc_b(3'b000, 16), 1'b0, 32'h110);

    // T3: speculative history, index hashing, jumps do not shift
    for (int i = 0; i < 2; i++) begin clr(); ex(32'h020, 8'h01, 1'b0, 1'b0); step(); end
    for (int i = 0; i < 2; i++) begin clr(); ex(32'h000, 8'h00, 1'b0, 1'b0); step(); end
    clr(); push("t3_ghr0", K_GHR, 32'h00);
    fetch(32'h040, enc_b(3'b000, 32)); exp_pred("t3_beq", 1'b1, 32'h60); step();
    clr(); push("t3_ghr1", K_GHR, 32'h01);
    fetch(32'h020, enc_b(3'b001, -8)); exp_pred("t3_bne", 1'b0, 32'h18); step();
    clr(); push("t3_ghr2", K_GHR, 32'h02);
    fetch(32'h004, enc_b(3'b000, 8)); exp_pred("t3_hash_idx0", 1'b0, 32'hC); step();
    clr(); push("t3_ghr4", K_GHR, 32'h04);
    fetch(32'h300, enc_jal(256)); exp_pred("t3_jal", 1'b1, 32'h400); step();
    clr(); push("t3_ghr_jal_hold", K_GHR, 32'h04);
    fetch(32'h010, enc_cbeqz(16)); exp_pred("t3_cbeqz", 1'b1, 32'h20); step();
    clr(); push("t3_ghr9", K_GHR, 32'h09);
    fetch(32'h300, enc_cj(3'b101, -32)); exp_pred("t3_cj", 1'b1, 32'h2E0); step();
    clr(); push("t3_ghr_cj_hold", K_GHR, 32'h09);
    fetch(32'h1000, enc_cj(3'b001, 256)); exp_pred("t3_cjal", 1'b1, 32'h1100); step();
    clr(); push("t3_ghr_cjal_hold", K_GHR, 32'h09);
    fetch_rdata_i = enc_jal(64); fetch_pc_i = 32'h200;
    push("t3_jal_novalid", K_TAKEN, 32'h0); step();

    // T4: mispredict recovery wins over a same-cycle fetch
    clr(); ex(32'h1FE, 8'h2D, 1'b0, 1'b1); step();
    clr(); push("t4_ghr5a", K_GHR, 32'h5A);
    fetch(32'h100, enc_b(3'b000, 16)); ex(32'h1FE, 8'h33, 1'b0, 1'b1);
    exp_pred("t4_pred", 1'b1, 32'h110); step();
    clr(); push("t4_ghr66", K_GHR, 32'h66); step();

    // T5: same-index read and write in one cycle, no bypass
    clr(); ex(32'h1FE, 8'h00, 1'b0, 1'b1); step();
    clr(); push("t5_ghr0", K_GHR, 32'h00);
    fetch(32'h160, enc_b(3'b000, 16)); ex(32'h060, 8'h80, 1'b0, 1'b1);
    exp_pred("t5_collide_old", 1'b1, 32'h170); step();
    probe("t5_next_new", 32'h160, enc_b(3'b000, 16), 1'b0, 32'h170);

    // T6: reset in RUN, then again mid-sweep
    clr(); fetch(32'h040, enc_b(3'b000, 32)); step();
    clr(); push("t6_ghr_pre", K_GHR, 32'h01); step();
    rst_i = 1'b1; step();
    rst_i = 1'b0;
    push("t6_ghr_reset", K_GHR, 32'h0);
    for (int i = 0; i < 100; i++) begin clr(); push("t6_done_low_a", K_DONE, 32'h0); step(); end
    rst_i = 1'b1; step();
    rst_i = 1'b0;
    for (int i = 0; i < 256; i++) begin clr(); push("t6_done_low_b", K_DONE, 32'h0); step(); end
    clr();
    push("t6_done_high", K_DONE, 32'h1);
    push("t6_ghr_run", K_GHR, 32'h0);
    fetch(32'h000, enc_b(3'b000, 16));
    exp_pred("t6_reinit", 1'b1, 32'h10);
    step();
    clr(); step();

    checks_total++;
    if (sb_q.size() == 0) begin
      checks_passed++;
    end else begin
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
